timer_ctrl: RTL and testbench

//  Sequencing controller for the timer comparator/output stage.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_prescaler.sv | 36 +++
 rtl/timer_ctrl.sv | 137 +++++++++++++
 tb/tb_timer_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer controller slice.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_e;

  localparam int unsigned TMR_CNT_W_DEF   = 8;
  localparam int unsigned TMR_PRESC_W_DEF = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a tick every div+1 RUN cycles.
// A divide value lowered below the running count resets the count without a tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESC_W = TMR_PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               restart,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  // Tick on the terminal count of the current divide value
  assign tick = run & (presc_cnt == div);

  // Prescale counter, cleared by restart and on reaching or passing div
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (restart) begin
      presc_cnt <= '0;
    end else if (run) begin
      if (presc_cnt >= div) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing controller: run FSM, up-counter, optional prescaler,
// and sticky edge-detected match flags (write-1-to-clear).
// Build option: TIMER_CTRL_PRESC_EN enables the prescaler; otherwise the
// counter ticks every RUN cycle and presc_div is ignored.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned CNT_W    = TMR_CNT_W_DEF,
  parameter int unsigned PRESC_W  = TMR_PRESC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                one_shot,
  input  logic [CNT_W-1:0]    period,
  input  logic [PRESC_W-1:0]  presc_div,
  input  logic [NUM_COMP-1:0] match,
  input  logic [NUM_COMP-1:0] flag_clr,
  output logic [CNT_W-1:0]    counter_value,
  output logic                en,
  output logic [NUM_COMP-1:0] flag,
  output logic                wrap,
  output logic                done
);

  tmr_state_e          state_q;
  tmr_state_e          state_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                wrap_d;
  logic                done_d;
  logic                run_c;
  logic                restart_c;
  logic                tick_c;
  logic [NUM_COMP-1:0] match_q;
  logic [NUM_COMP-1:0] rise_c;

  assign run_c     = (state_q == RUN);
  // stop always wins over a same-cycle start
  assign restart_c = start & ~stop;

`ifdef TIMER_CTRL_PRESC_EN
  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .run     (run_c),
    .restart (restart_c),
    .div     (presc_div),
    .tick    (tick_c)
  );
`else
  logic unused_presc_div;
  assign unused_presc_div = ^presc_div;
  assign tick_c           = run_c;
`endif

  // Next-state, next-count and pulse decode
  always_comb begin
    state_d = state_q;
    cnt_d   = counter_value;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (restart_c) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          cnt_d = '0;
        end else if (tick_c) begin
          if (counter_value == period) begin
            if (one_shot) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d  = '0;
              wrap_d = 1'b1;
            end
          end else begin
            cnt_d = counter_value + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (restart_c) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      counter_value <= '0;
      en            <= 1'b0;
      wrap          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_value <= cnt_d;
      en            <= (state_d == RUN);
      wrap          <= wrap_d;
      done          <= done_d;
    end
  end

  // Rising match edges only count while running
  assign rise_c = match & ~match_q & {NUM_COMP{en}};

  // Sticky flags; a new rise beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= '0;
      flag    <= '0;
    end else begin
      match_q <= match;
      flag    <= (flag & ~flag_clr) | rise_c;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus a randomized
// run against a cycle-level behavioural model.
module tb_timer_ctrl;

  localparam int unsigned NC = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          one_shot;
  logic [CW-1:0] period;
  logic [PW-1:0] presc_div;
  logic [NC-1:0] match;
  logic [NC-1:0] flag_clr;
  logic [CW-1:0] counter_value;
  logic          en;
  logic [NC-1:0] flag;
  logic          wrap;
  logic          done;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_run;
  bit [CW-1:0] m_cnt;
  bit [PW-1:0] m_pc;
  bit [NC-1:0] m_flag;
  bit [NC-1:0] m_mq;
  bit          m_wrap;
  bit          m_done;

  timer_ctrl #(.NUM_COMP(NC), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .one_shot      (one_shot),
    .period        (period),
    .presc_div     (presc_div),
    .match         (match),
    .flag_clr      (flag_clr),
    .counter_value (counter_value),
    .en            (en),
    .flag          (flag),
    .wrap          (wrap),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Advance one clock, update the model from the inputs seen at the edge
  task automatic step();
    bit          tick;
    bit          accept;
    bit [NC-1:0] rise;
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_cnt = '0; m_pc = '0; m_flag = '0; m_mq = '0;
      m_wrap = 0; m_done = 0;
    end else begin
      rise   = match & ~m_mq & (m_run ? {NC{1'b1}} : {NC{1'b0}});
`ifdef TIMER_CTRL_PRESC_EN
      tick   = m_run && (m_pc == presc_div);
`else
      tick   = m_run;
`endif
      accept = start && !stop;
      m_flag = (m_flag & ~flag_clr) | rise;
      m_mq   = match;
      m_wrap = 0;
      m_done = 0;
      if (accept) m_pc = '0;
      else if (m_run) m_pc = (m_pc >= presc_div) ? '0 : m_pc + 8'd1;
      if (stop) begin
        m_run = 0;
      end else if (start) begin
        m_run = 1;
        m_cnt = '0;
      end else if (m_run && tick) begin
        if (m_cnt == period) begin
          if (one_shot) begin
            m_done = 1;
            m_run  = 0;
          end else begin
            m_cnt  = '0;
            m_wrap = 1;
          end
        end else begin
          m_cnt = m_cnt + 8'd1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; stop = 0; one_shot = 0; period = 8'd4;
    presc_div = '0; match = '0; flag_clr = '0;
    step(); step();
    rst = 0;
    checks++; if (counter_value !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", counter_value); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", en); end
    checks++; if (flag !== 3'b000) begin errors++; $display("FAIL reset_flag: got %b expected 000", flag); end
    checks++; if ({wrap, done} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {wrap, done}); end
  endtask

  task automatic test_periodic();
    int unsigned ec;
    period = 8'd4; one_shot = 0; presc_div = '0;
    start = 1; step(); start = 0;
    checks++; if (en !== 1'b1 || counter_value !== 8'd0) begin errors++; $display("FAIL per_start: got en=%0b cnt=%0d expected en=1 cnt=0", en, counter_value); end
    for (int k = 1; k <= 11; k++) begin
      step();
      ec = k % 5;
      checks++; if (counter_value !== CW'(ec)) begin errors++; $display("FAIL per_cnt k=%0d: got %0d expected %0d", k, counter_value, ec); end
      checks++; if (wrap !== (ec == 0)) begin errors++; $display("FAIL per_wrap k=%0d: got %0b expected %0b", k, wrap, ec == 0); end
    end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_one_shot();
    period = 8'd3; one_shot = 1; presc_div = '0;
    start = 1; step(); start = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (counter_value !== CW'(k) || en !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL os_run k=%0d: got cnt=%0d en=%0b done=%0b expected cnt=%0d en=1 done=0", k, counter_value, en, done, k); end
    end
    step();
    checks++; if (done !== 1'b1 || en !== 1'b0 || counter_value !== 8'd3) begin errors++; $display("FAIL os_done: got done=%0b en=%0b cnt=%0d expected 1 0 3", done, en, counter_value); end
    step();
    checks++; if (done !== 1'b0 || en !== 1'b0 || counter_value !== 8'd3) begin errors++; $display("FAIL os_idle: got done=%0b en=%0b cnt=%0d expected 0 0 3", done, en, counter_value); end
    // period 0 completes on the first tick; start during DONE restarts
    period = 8'd0;
    start = 1; step(); start = 0;
    step();
    checks++; if (done !== 1'b1 || counter_value !== 8'd0) begin errors++; $display("FAIL os_p0: got done=%0b cnt=%0d expected 1 0", done, counter_value); end
    start = 1; step(); start = 0;
    checks++; if (en !== 1'b1 || done !== 1'b0 || counter_value !== 8'd0) begin errors++; $display("FAIL os_restart: got en=%0b done=%0b cnt=%0d expected 1 0 0", en, done, counter_value); end
    stop = 1; step(); stop = 0; one_shot = 0;
  endtask

`ifdef TIMER_CTRL_PRESC_EN
  task automatic test_prescaler();
    int unsigned ec;
    period = 8'd2; one_shot = 0; presc_div = 8'd2;
    start = 1; step(); start = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      ec = (k / 3) % 3;
      checks++; if (counter_value !== CW'(ec) || wrap !== (k == 9)) begin errors++; $display("FAIL presc k=%0d: got cnt=%0d wrap=%0b expected cnt=%0d wrap=%0b", k, counter_value, wrap, ec, k == 9); end
    end
    stop = 1; step(); stop = 0; presc_div = '0;
  endtask
`endif

  task automatic test_stop_start();
    period = 8'd20; one_shot = 0; presc_div = '0;
    start = 1; step(); start = 0;
    repeat (5) step();
    checks++; if (counter_value !== 8'd5) begin errors++; $display("FAIL ss_cnt5: got %0d expected 5", counter_value); end
    stop = 1; step(); stop = 0;
    repeat (3) step();
    checks++; if (en !== 1'b0 || counter_value !== 8'd5) begin errors++; $display("FAIL ss_hold: got en=%0b cnt=%0d expected 0 5", en, counter_value); end
    stop = 1; step(); stop = 0;
    checks++; if (en !== 1'b0 || counter_value !== 8'd5) begin errors++; $display("FAIL ss_idle_stop: got en=%0b cnt=%0d expected 0 5", en, counter_value); end
    start = 1; step(); start = 0;
    checks++; if (en !== 1'b1 || counter_value !== 8'd0) begin errors++; $display("FAIL ss_restart: got en=%0b cnt=%0d expected 1 0", en, counter_value); end
    step(); step();
    start = 1; stop = 1; step(); start = 0; stop = 0;
    checks++; if (en !== 1'b0 || counter_value !== 8'd2) begin errors++; $display("FAIL ss_both: got en=%0b cnt=%0d expected 0 2", en, counter_value); end
  endtask

  task automatic test_flags();
    period = 8'd50; one_shot = 0;
    start = 1; step(); start = 0;
    match = '0; step();
    match = 3'b010; flag_clr = 3'b010; step();
    checks++; if (flag !== 3'b010) begin errors++; $display("FAIL flg_set_clr: got %b expected 010", flag); end
    flag_clr = '0; step();
    checks++; if (flag !== 3'b010) begin errors++; $display("FAIL flg_sticky: got %b expected 010", flag); end
    flag_clr = 3'b010; step(); flag_clr = '0;
    checks++; if (flag !== 3'b000) begin errors++; $display("FAIL flg_clear: got %b expected 000", flag); end
    step();
    checks++; if (flag !== 3'b000) begin errors++; $display("FAIL flg_held: got %b expected 000", flag); end
    match = '0; step();
    stop = 1; step(); stop = 0;
    match = 3'b111; step(); match = '0;
    checks++; if (flag !== 3'b000) begin errors++; $display("FAIL flg_idle: got %b expected 000", flag); end
  endtask

  task automatic test_reset_mid();
    period = 8'd20; one_shot = 0;
    start = 1; step(); start = 0;
    match = 3'b001; step();
    repeat (6) step();
    checks++; if (counter_value !== 8'd7 || flag !== 3'b001) begin errors++; $display("FAIL rm_pre: got cnt=%0d flag=%b expected 7 001", counter_value, flag); end
    rst = 1; step(); rst = 0; match = '0;
    checks++; if (counter_value !== 8'd0 || en !== 1'b0 || flag !== 3'b000 || wrap !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_post: got cnt=%0d en=%0b flag=%b wrap=%0b done=%0b expected all 0", counter_value, en, flag, wrap, done); end
  endtask

  task automatic test_period_lower();
    int n;
    period = 8'd10; one_shot = 0;
    start = 1; step(); start = 0;
    repeat (8) step();
    period = 8'd5; step();
    checks++; if (counter_value !== 8'd9) begin errors++; $display("FAIL pl_past: got %0d expected 9", counter_value); end
    n = 0;
    while (counter_value !== 8'd255 && n < 300) begin step(); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL pl_timeout: got %0d expected 255", counter_value); end
    step();
    checks++; if (counter_value !== 8'd0 || wrap !== 1'b0) begin errors++; $display("FAIL pl_rollover: got cnt=%0d wrap=%0b expected 0 0", counter_value, wrap); end
    repeat (5) step();
    step();
    checks++; if (counter_value !== 8'd0 || wrap !== 1'b1) begin errors++; $display("FAIL pl_wrap: got cnt=%0d wrap=%0b expected 0 1", counter_value, wrap); end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      match    = NC'($urandom);
      flag_clr = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
      if ($urandom_range(0, 39) == 0) period = ($urandom_range(0, 9) == 0) ? 8'd200 : CW'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) presc_div = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) one_shot = ~one_shot;
      step();
      checks++; if (counter_value !== m_cnt) begin errors++; $display("FAIL rnd_cnt i=%0d: got %0d expected %0d", i, counter_value, m_cnt); end
      checks++; if (en !== m_run) begin errors++; $display("FAIL rnd_en i=%0d: got %0b expected %0b", i, en, m_run); end
      checks++; if (flag !== m_flag) begin errors++; $display("FAIL rnd_flag i=%0d: got %b expected %b", i, flag, m_flag); end
      checks++; if (wrap !== m_wrap || done !== m_done) begin errors++; $display("FAIL rnd_pulse i=%0d: got wrap=%0b done=%0b expected %0b %0b", i, wrap, done, m_wrap, m_done); end
    end
    rst = 0; start = 0; stop = 0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_one_shot();
`ifdef TIMER_CTRL_PRESC_EN
    test_prescaler();
`endif
    test_stop_start();
    test_flags();
    test_reset_mid();
    test_period_lower();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
